vram_arbiter: RTL
=================

Name: vram_arbiter

Overview:
- Shares the single-port 12-bit frame-buffer RAM (15-bit address, 160x120 = 19200 entries) between three requesters.
- Requester 1: VGA scan-out read path, driven by the pixel-to-RAM address mapper.
- Requester 2: a draw unit writing individual pixels through a req/ack handshake.
- Requester 3: a built-in screen-clear engine that fills every entry with one colour.
- Fixed priority: display read > draw write > clear write. One RAM operation per clock.

Parameters:
- AW, 15, RAM address width
- DW, 12, RAM data width (RGB444)
- DEPTH, 19200, number of entries the clear engine fills (addresses 0..DEPTH-1)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- disp_req  in  1  display read request, sampled every cycle
- disp_addr  in  AW  display read address
- disp_data  out  DW  read data (= ram_rdata), qualified by disp_valid
- disp_valid  out  1  read data valid
- wr_req  in  1  draw write request; held high until wr_ack
- wr_addr  in  AW  draw write address; stable while wr_req is high
- wr_data  in  DW  draw write data; stable while wr_req is high
- wr_ack  out  1  one-cycle pulse: write issued
- clr_start  in  1  pulse: start or restart a clear
- clr_color  in  DW  fill colour, sampled on clr_start
- clr_busy  out  1  clear in progress
- ram_addr  out  AW  RAM address (registered)
- ram_we  out  1  RAM write enable (registered)
- ram_wdata  out  DW  RAM write data (registered)
- ram_rdata  in  DW  RAM read data, valid one cycle after the address is presented

Behaviour:
- Reset (rstn low, asynchronous): all registered outputs are 0 (ram_addr, ram_we, ram_wdata, wr_ack, disp_valid, clr_busy). Clear counter is 0, state is IDLE, latched colour is 0. Takes effect immediately, including mid-clear or mid-handshake; no pending operation survives reset.
- Arbitration in cycle N, combinational on inputs. The winner is registered onto the ram_* outputs at the end of N, so the RAM sees it in N+1.
  - disp_req=1: read. ram_addr<=disp_addr, ram_we<=0.
  - Else if wr_req=1 and wr_ack=0: write. ram_addr<=wr_addr, ram_wdata<=wr_data, ram_we<=1, wr_ack<=1.
  - Else if state is CLEAR: write. ram_addr<=clr_cnt, ram_wdata<=latched colour, ram_we<=1, clr_cnt advances.
  - Else: idle. ram_we<=0; ram_addr holds its value.
- The wr_ack=0 condition blocks a double grant in the ack cycle. A continuously requesting draw unit therefore gets at most one write every 2 cycles.
- Read pipeline: a read granted in N gives disp_valid=1 in N+2, with disp_data=ram_rdata (combinational passthrough). disp_valid is a 2-stage delay of the read grant. Back-to-back reads deliver one valid per cycle.
- wr_ack is high for exactly one cycle (N+1) per granted write.
- The display starves draw and clear writes for as long as disp_req is held. No fairness guarantee; the team relies on blanking intervals for write bandwidth.
- Clear FSM:
  - IDLE -> CLEAR on clr_start: clr_cnt<=0, colour<=clr_color, clr_busy<=1 from N+1.
  - CLEAR: clr_cnt increments only on cycles where the clear engine wins arbitration.
  - CLEAR -> IDLE on the cycle the write to DEPTH-1 is granted: clr_busy<=0 in the next cycle, clr_cnt<=0.
  - clr_start while in CLEAR restarts from address 0 with the newly sampled colour. A clear write granted in that same cycle is still issued.
  - clr_start in the same cycle as reset release is ignored until rstn is sampled high.
- Width rules: clr_cnt is AW bits and never exceeds DEPTH-1, so there is no wrap past DEPTH. Addresses at or above DEPTH from requesters pass through unchecked.

Test Plan:
- Reset then idle: rstn low with random inputs -> all outputs 0. After release with no requests, ram_we stays 0 for 10 cycles.
- Read latency: disp_req=1 with disp_addr=0x0010 at N, RAM model returns 0xABC -> ram_addr=0x0010, ram_we=0 at N+1; disp_valid=1, disp_data=0xABC at N+2. 4 back-to-back reads -> 4 consecutive valids in order.
- Write handshake: wr_req held with addr 0x1234, data 0xF00, no disp_req -> single write at N+1, wr_ack pulses once. With wr_req held for 6 cycles, writes are issued on alternate cycles only.
- Priority: disp_req and wr_req both high for 5 cycles, then disp_req low -> no write during those 5 cycles. Write and wr_ack occur in the cycle after disp_req drops, and wr_data is preserved.
- Full clear: clr_start with clr_color=0x0F0, no other traffic -> 19200 writes to addresses 0..19199, all 0x0F0. clr_busy is high for exactly 19200 cycles and clr_busy=0 after the last write.
- Clear interruption: restart clr_start with colour 0x00F at clr_cnt=500 -> next clear address is 0 with 0x00F. A mid-clear wr_req is interleaved with correct data. Asserting rstn low mid-clear -> clr_busy=0 immediately and no further writes.

Source files
------------

// File: rtl/vram_arbiter.sv
// Frame-buffer RAM arbiter: display reads beat draw writes, which beat the
// built-in screen-clear engine. One registered RAM operation per clock.
module vram_arbiter #(
  parameter int AW    = 15,
  parameter int DW    = 12,
  parameter int DEPTH = 19200
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic [DW-1:0] disp_data,
  output logic          disp_valid,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  input  logic          clr_start,
  input  logic [DW-1:0] clr_color,
  output logic          clr_busy,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic [DW-1:0] color_q, color_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic          ram_we_q, ram_we_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  logic          wr_ack_q, wr_ack_d;
  logic          rd_vld_p1_q, rd_vld_p1_d;
  logic          disp_valid_q;
  logic          gnt_rd, gnt_wr, gnt_clr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      clr_cnt_q    <= '0;
      color_q      <= '0;
      ram_addr_q   <= '0;
      ram_we_q     <= 1'b0;
      ram_wdata_q  <= '0;
      wr_ack_q     <= 1'b0;
      rd_vld_p1_q  <= 1'b0;
      disp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      color_q      <= color_d;
      ram_addr_q   <= ram_addr_d;
      ram_we_q     <= ram_we_d;
      ram_wdata_q  <= ram_wdata_d;
      wr_ack_q     <= wr_ack_d;
      rd_vld_p1_q  <= rd_vld_p1_d;
      disp_valid_q <= rd_vld_p1_q;
    end
  end

  // wr_ack_q masks the draw request in its ack cycle so one request is not granted twice
  always_comb begin
    gnt_rd  = disp_req;
    gnt_wr  = !disp_req && wr_req && !wr_ack_q;
    gnt_clr = !disp_req && !gnt_wr && (state_q == CLEAR);
  end

  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    wr_ack_d    = gnt_wr;
    rd_vld_p1_d = gnt_rd;
    if (gnt_rd) begin
      ram_addr_d = disp_addr;
    end else if (gnt_wr) begin
      ram_addr_d  = wr_addr;
      ram_wdata_d = wr_data;
      ram_we_d    = 1'b1;
    end else if (gnt_clr) begin
      ram_addr_d  = clr_cnt_q;
      ram_wdata_d = color_q;
      ram_we_d    = 1'b1;
    end
  end

  // A restart overrides the normal advance; the write granted this cycle still goes out
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    color_d   = color_q;
    if (gnt_clr) begin
      if (clr_cnt_q == LAST_ADDR) begin
        state_d   = IDLE;
        clr_cnt_d = '0;
      end else begin
        clr_cnt_d = clr_cnt_q + 1'b1;
      end
    end
    if (clr_start) begin
      state_d   = CLEAR;
      clr_cnt_d = '0;
      color_d   = clr_color;
    end
  end

  assign disp_data  = ram_rdata;
  assign disp_valid = disp_valid_q;
  assign wr_ack     = wr_ack_q;
  assign clr_busy   = (state_q == CLEAR);
  assign ram_addr   = ram_addr_q;
  assign ram_we     = ram_we_q;
  assign ram_wdata  = ram_wdata_q;

endmodule
